lsu_req_ctrl: RTL and testbench
===============================

Name: lsu_req_ctrl

Overview:
- Sequences load/store requests from the execute stage onto the single-port data-memory bus.
- Bus protocol is req/gnt/rvalid.
- Tracks in-flight loads in order and returns aligned, sign/zero-extended write-back data to the register file.
- Sits between the address-generation stage and the RIB data port; stalls issue when the bus or the load tracker is busy.

Parameters:
- OUTSTANDING_DEPTH, 2, max granted-but-unanswered loads (power of two, >=1).
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width (4 byte lanes).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  issue stage presents a memory op
- req_ready_o  out  1  op accepted this cycle
- req_we_i  in  1  1=store, 0=load
- req_addr_i  in  ADDR_W  effective byte address
- req_wdata_i  in  DATA_W  store data, lane-aligned
- req_wmask_i  in  4  store byte mask
- req_size_i  in  2  00 byte, 01 half, 10 word
- req_unsigned_i  in  1  zero-extend load
- req_rd_i  in  5  load destination register
- flush_i  in  1  interrupt/flush; kill pending work
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  word-aligned address (low 2 bits zero)
- bus_wdata_o  out  DATA_W  write data
- bus_wmask_o  out  4  write byte mask
- bus_gnt_i  in  1  bus accepts the command this cycle
- bus_rvalid_i  in  1  load response valid
- bus_rdata_i  in  DATA_W  load response data
- wb_valid_o  out  1  write-back valid
- wb_rd_o  out  5  write-back register
- wb_data_o  out  32  extended load data
- misalign_o  out  1  one-cycle pulse: rejected misaligned op
- busy_o  out  1  command pending or loads outstanding

Behaviour:
- Reset: all outputs 0, command register empty, tracker empty, discard counter 0.
- Command register (one entry):
  - Op accepted when req_valid_i && req_ready_o.
  - Accepted op is latched; bus_req_o rises the next cycle.
  - bus_req_o and all bus_* fields stay stable until bus_gnt_i.
- req_ready_o = !flush_i && (cmd empty || (bus_req_o && bus_gnt_i)). A back-to-back op therefore issues every cycle when gnt stays high.
- Load gating: for a pending load, bus_req_o is asserted only while the tracker is not full. Stores are never gated.
- Load grant: pushes {rd, addr[1:0], size, unsigned} into the in-order tracker.
- Stores: no response is expected.
- Load response: each bus_rvalid_i pops the tracker head.
  - Registered write-back one cycle later: wb_valid_o=1, wb_rd_o, wb_data_o.
  - Byte: lane addr[1:0]; half: lane addr[1]; word: full data.
  - Sign-extended unless req_unsigned_i was set.
  - Latency from gnt is bus-dependent; from rvalid to wb_valid_o is exactly 1 cycle.
- Simultaneous load grant and rvalid: push and pop in the same cycle; count unchanged.
- rvalid with tracker empty: ignored; no wb; flagged by an assertion in simulation.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0):
  - The op is accepted and dropped.
  - misalign_o pulses the next cycle.
  - No bus request, no wb.
- flush_i:
  - Clears the ungranted command; bus_req_o is 0 the next cycle.
  - A grant in the same cycle as flush_i still counts as granted.
  - Every granted-but-unanswered load is marked discard: its rvalid pops the tracker with wb_valid_o suppressed.
  - New ops may be accepted the cycle after flush_i while discards drain.
- busy_o = cmd valid || tracker non-empty.
- Address wrap: none; addresses pass straight through, low bits masked.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- When defined, adds perf_load_cnt_o, perf_store_cnt_o and perf_stall_cnt_o (32 bits each, wrap at 2^32, reset 0).
  - Load/store counters increment on bus grant.
  - perf_stall_cnt_o increments each cycle req_valid_i && !req_ready_o.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package lsu_pkg:
  - mem size enum (BYTE/HALF/WORD)
  - tracker entry struct
  - command struct
  - load extract/extend function
  - misalign check function
- Sub-module lsu_load_tracker: synchronous FIFO of entries with depth OUTSTANDING_DEPTH, push/pop/full/empty/count, and a per-entry discard mark-all input.

Test Plan:
- Load word addr 0x100, gnt same cycle, rvalid 2 cycles later with 0x8000_00F0, rd=5 -> wb_valid 1 cycle after rvalid, wb_rd=5, wb_data=0x8000_00F0.
- Signed byte load addr 0x103, rdata 0x80AA_BBCC -> wb_data 0xFFFF_FF80; same op unsigned -> 0x0000_0080.
- Three loads, gnt held high, no rvalid, depth 2 -> third load's bus_req_o low, req_ready_o low until first rvalid, then third issues; wb order 1,2,3.
- Store sw addr 0x200 data 0x1234_5678, gnt delayed 3 cycles -> bus_addr/wdata/wmask=4'hF stable all 4 cycles, no wb.
- Two loads granted, flush_i pulsed, then 2 rvalids plus a new load -> first two responses produce no wb; new load writes back normally.
- Lh at addr 0x101 -> misalign_o pulse, bus_req_o stays 0, busy_o stays 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store request controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] off;
        mem_size_e  size;
        logic       uns;
    } trk_entry_t;

    typedef struct packed {
        logic       we;
        logic [3:0] wmask;
        trk_entry_t ld;
    } cmd_t;

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(logic [31:0] rdata, trk_entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{e.off, 3'b000} +: 8];
        h = e.off[1] ? rdata[31:16] : rdata[15:0];
        case (e.size)
            SZ_BYTE: return {{24{~e.uns & b[7]}}, b};
            SZ_HALF: return {{16{~e.uns & h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_tracker.sv
// In-order FIFO of granted loads; each entry carries a discard mark set by flush.
module lsu_load_tracker
    import lsu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  trk_entry_t       push_entry,
    input  logic             pop,
    input  logic             discard_all,
    output trk_entry_t       head,
    output logic             head_discard,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trk_entry_t       mem [DEPTH];
    logic [DEPTH-1:0] disc;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head         = mem[rd_ptr];
    assign head_discard = disc[rd_ptr];
    assign full         = count == CNT_W'(DEPTH);
    assign empty        = count == '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disc   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // A load granted in the flush cycle is itself stale, so it inherits the mark.
            if (discard_all) disc <= '1;
            if (push) begin
                disc[wr_ptr] <= discard_all;
                wr_ptr       <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/lsu_req_ctrl.sv
// Load/store request sequencer onto a req/gnt/rvalid data bus with in-order load write-back.
// Optional perf counters are built when LSU_PERF_CNT_EN is defined.
module lsu_req_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned OUTSTANDING_DEPTH = 2,
    parameter int unsigned ADDR_W            = 32,
    parameter int unsigned DATA_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [3:0]        req_wmask_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [4:0]        req_rd_i,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [3:0]        bus_wmask_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic              misalign_o,
    output logic              busy_o
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_load_cnt_o,
    output logic [31:0]       perf_store_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING_DEPTH + 1);

    logic              cmd_valid;
    cmd_t              cmd, req_cmd;
    logic [ADDR_W-3:0] cmd_word;
    logic [DATA_W-1:0] cmd_wdata;

    logic              gnt, accept, mis, push, pop;
    logic              trk_full, trk_empty, trk_head_disc;
    trk_entry_t        trk_head;
    logic [CNT_W-1:0]  trk_count;

    always_comb begin
        req_cmd        = '0;
        req_cmd.we     = req_we_i;
        req_cmd.wmask  = req_wmask_i;
        req_cmd.ld.rd  = req_rd_i;
        req_cmd.ld.off = req_addr_i[1:0];
        req_cmd.ld.size = mem_size_e'(req_size_i);
        req_cmd.ld.uns = req_unsigned_i;
    end

    // Loads wait while the tracker is full; stores never expect a response.
    assign bus_req_o   = cmd_valid && (cmd.we || !trk_full);
    assign gnt         = bus_req_o && bus_gnt_i;
    assign req_ready_o = !flush_i && (!cmd_valid || gnt);
    assign accept      = req_valid_i && req_ready_o;
    assign mis         = is_misaligned(req_cmd.ld.size, req_cmd.ld.off);
    assign push        = gnt && !cmd.we;
    assign pop         = bus_rvalid_i && !trk_empty;

    assign bus_we_o    = cmd.we;
    assign bus_addr_o  = {cmd_word, 2'b00};
    assign bus_wdata_o = cmd_wdata;
    assign bus_wmask_o = cmd.wmask;
    assign busy_o      = cmd_valid || (trk_count != '0);

    lsu_load_tracker #(.DEPTH(OUTSTANDING_DEPTH)) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_entry   (cmd.ld),
        .pop          (pop),
        .discard_all  (flush_i),
        .head         (trk_head),
        .head_discard (trk_head_disc),
        .full         (trk_full),
        .empty        (trk_empty),
        .count        (trk_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid  <= 1'b0;
            cmd        <= '0;
            cmd_word   <= '0;
            cmd_wdata  <= '0;
            misalign_o <= 1'b0;
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
        end else begin
            misalign_o <= accept && mis;
            wb_valid_o <= pop && !(trk_head_disc || flush_i);
            if (pop) begin
                wb_rd_o   <= trk_head.rd;
                wb_data_o <= load_extend(bus_rdata_i[31:0], trk_head);
            end
            if (accept && !mis) begin
                cmd_valid <= 1'b1;
                cmd       <= req_cmd;
                cmd_word  <= req_addr_i[ADDR_W-1:2];
                cmd_wdata <= req_wdata_i;
            end else if (gnt || flush_i) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    rvalid_needs_load: assert property (@(posedge clk) disable iff (rst)
        bus_rvalid_i |-> !trk_empty);

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_cnt_o  <= '0;
            perf_store_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (gnt && !cmd.we)               perf_load_cnt_o  <= perf_load_cnt_o + 1'b1;
            if (gnt && cmd.we)                perf_store_cnt_o <= perf_store_cnt_o + 1'b1;
            if (req_valid_i && !req_ready_o)  perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Directed bench for lsu_req_ctrl: load-extension vector table plus multi-cycle sequences.
module tb_lsu_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wmask_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wmask_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o, busy_o;

    int n_pass = 0;
    int n_total = 0;

    lsu_req_ctrl #(.OUTSTANDING_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_wmask_i    (req_wmask_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_rd_i       (req_rd_i),
        .flush_i        (flush_i),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_wmask_o    (bus_wmask_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_rdata_i    (bus_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wb_rd_o        (wb_rd_o),
        .wb_data_o      (wb_data_o),
        .misalign_o     (misalign_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [4:0] rd, input logic [31:0] wdata,
                             input logic [3:0] wmask);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_rd_i       = rd;
        req_wdata_i    = wdata;
        req_wmask_i    = wmask;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0100, 2'b10, 1'b0, 32'h8000_00F0, 32'h8000_00F0, 1'b0};
        vecs[1]  = '{32'h0000_0103, 2'b00, 1'b0, 32'h80AA_BBCC, 32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{32'h0000_0103, 2'b00, 1'b1, 32'h80AA_BBCC, 32'h0000_0080, 1'b0};
        vecs[3]  = '{32'h0000_0100, 2'b00, 1'b0, 32'h80AA_BBCC, 32'hFFFF_FFCC, 1'b0};
        vecs[4]  = '{32'h0000_0101, 2'b00, 1'b1, 32'h80AA_BBCC, 32'h0000_00BB, 1'b0};
        vecs[5]  = '{32'h0000_0102, 2'b01, 1'b0, 32'h80AA_BBCC, 32'hFFFF_80AA, 1'b0};
        vecs[6]  = '{32'h0000_0100, 2'b01, 1'b1, 32'h80AA_BBCC, 32'h0000_BBCC, 1'b0};
        vecs[7]  = '{32'h0000_0104, 2'b01, 1'b0, 32'h1234_7FFF, 32'h0000_7FFF, 1'b0};
        vecs[8]  = '{32'h0000_0105, 2'b00, 1'b0, 32'h0000_7F00, 32'h0000_007F, 1'b0};
        vecs[9]  = '{32'h0000_0101, 2'b01, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{32'h0000_0102, 2'b10, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{32'h0000_0103, 2'b10, 1'b1, 32'h0,         32'h0,         1'b1};

        rst = 1'b1;
        req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0; req_wmask_i = 0;
        req_size_i = 0; req_unsigned_i = 0; req_rd_i = 0; flush_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        tick(); tick();
        chk("rst_bus_req",  bus_req_o,  0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_busy",     busy_o,     0);
        chk("rst_bus_addr", bus_addr_o, 0);
        rst = 1'b0;
        tick();

        // Single-load vectors: grant on first request cycle, response two cycles later.
        for (int i = 0; i < 12; i++) begin
            drive_req(1'b0, vecs[i].addr, vecs[i].size, vecs[i].uns, 5'(i + 1), 32'h0, 4'h0);
            bus_gnt_i = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), req_ready_o, 1);
            tick();
            req_valid_i = 1'b0;
            if (vecs[i].mis) begin
                chk($sformatf("v%0d_misalign", i), misalign_o, 1);
                chk($sformatf("v%0d_mis_breq", i), bus_req_o, 0);
                chk($sformatf("v%0d_mis_busy", i), busy_o, 0);
                tick();
                chk($sformatf("v%0d_mis_pulse", i), misalign_o, 0);
                chk($sformatf("v%0d_mis_wb", i), wb_valid_o, 0);
                bus_gnt_i = 1'b0;
            end else begin
                chk($sformatf("v%0d_breq", i), bus_req_o, 1);
                chk($sformatf("v%0d_baddr", i), bus_addr_o, vecs[i].addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_bwe", i), bus_we_o, 0);
                tick();
                bus_gnt_i = 1'b0;
                chk($sformatf("v%0d_breq_drop", i), bus_req_o, 0);
                chk($sformatf("v%0d_busy", i), busy_o, 1);
                tick();
                chk($sformatf("v%0d_no_early_wb", i), wb_valid_o, 0);
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = vecs[i].rdata;
                tick();
                bus_rvalid_i = 1'b0;
                chk($sformatf("v%0d_wb_valid", i), wb_valid_o, 1);
                chk($sformatf("v%0d_wb_rd", i), wb_rd_o, 32'(i + 1));
                chk($sformatf("v%0d_wb_data", i), wb_data_o, vecs[i].exp);
                chk($sformatf("v%0d_idle", i), busy_o, 0);
                tick();
                chk($sformatf("v%0d_wb_pulse", i), wb_valid_o, 0);
            end
        end

        // Three back-to-back loads against a depth-2 tracker.
        bus_gnt_i = 1'b1;
        drive_req(1'b0, 32'h10, 2'b10, 1'b0, 5'd1, 32'h0, 4'h0);
        tick();
        drive_req(1'b0, 32'h14, 2'b10, 1'b0, 5'd2, 32'h0, 4'h0);
        #1;
        chk("b2b_ready1", req_ready_o, 1);
        tick();
        drive_req(1'b0, 32'h18, 2'b10, 1'b0, 5'd3, 32'h0, 4'h0);
        #1;
        chk("b2b_ready2", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        chk("full_breq", bus_req_o, 0);
        chk("full_ready", req_ready_o, 0);
        chk("full_addr", bus_addr_o, 32'h18);
        tick();
        chk("full_breq_hold", bus_req_o, 0);
        chk("full_ready_hold", req_ready_o, 0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11;
        tick();
        chk("ord_wb1_valid", wb_valid_o, 1);
        chk("ord_wb1_rd", wb_rd_o, 1);
        chk("ord_wb1_data", wb_data_o, 32'h11);
        chk("third_breq", bus_req_o, 1);
        chk("third_ready", req_ready_o, 1);
        bus_rvalid_i = 1'b0;
        tick();
        chk("third_granted", bus_req_o, 0);
        chk("ord_gap", wb_valid_o, 0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h22;
        tick();
        chk("ord_wb2_rd", wb_rd_o, 2);
        chk("ord_wb2_data", wb_data_o, 32'h22);
        bus_rdata_i = 32'h33;
        tick();
        bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
        chk("ord_wb3_valid", wb_valid_o, 1);
        chk("ord_wb3_rd", wb_rd_o, 3);
        chk("ord_wb3_data", wb_data_o, 32'h33);
        tick();
        chk("ord_idle", busy_o, 0);

        // Store held on the bus for four cycles until granted.
        drive_req(1'b1, 32'h200, 2'b10, 1'b0, 5'd0, 32'h1234_5678, 4'hF);
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus_gnt_i = 1'b1;
            #1;
            chk($sformatf("st%0d_breq", k), bus_req_o, 1);
            chk($sformatf("st%0d_we", k), bus_we_o, 1);
            chk($sformatf("st%0d_addr", k), bus_addr_o, 32'h200);
            chk($sformatf("st%0d_wdata", k), bus_wdata_o, 32'h1234_5678);
            chk($sformatf("st%0d_wmask", k), bus_wmask_o, 4'hF);
            chk($sformatf("st%0d_ready", k), req_ready_o, (k == 3) ? 1 : 0);
            tick();
        end
        bus_gnt_i = 1'b0;
        chk("st_done_breq", bus_req_o, 0);
        chk("st_done_busy", busy_o, 0);
        chk("st_no_wb", wb_valid_o, 0);
        tick();
        chk("st_no_wb2", wb_valid_o, 0);

        // Flush with two loads outstanding, then a fresh load.
        bus_gnt_i = 1'b1;
        drive_req(1'b0, 32'h20, 2'b10, 1'b0, 5'd7, 32'h0, 4'h0);
        tick();
        drive_req(1'b0, 32'h24, 2'b10, 1'b0, 5'd8, 32'h0, 4'h0);
        tick();
        req_valid_i = 1'b0;
        tick();
        bus_gnt_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk("fl_ready_low", req_ready_o, 0);
        tick();
        flush_i = 1'b0;
        drive_req(1'b0, 32'h28, 2'b10, 1'b0, 5'd9, 32'h0, 4'h0);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_DEAD;
        #1;
        chk("fl_ready_after", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        chk("fl_disc1_wb", wb_valid_o, 0);
        bus_rdata_i = 32'h0000_BEEF;
        bus_gnt_i = 1'b1;
        tick();
        chk("fl_disc2_wb", wb_valid_o, 0);
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        chk("fl_new_busy", busy_o, 1);
        tick();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0555;
        tick();
        bus_rvalid_i = 1'b0;
        chk("fl_new_wb_valid", wb_valid_o, 1);
        chk("fl_new_wb_rd", wb_rd_o, 9);
        chk("fl_new_wb_data", wb_data_o, 32'h0000_0555);
        tick();
        chk("fl_end_busy", busy_o, 0);

        // Flush drops an ungranted command.
        drive_req(1'b1, 32'h300, 2'b10, 1'b0, 5'd0, 32'hA5A5_A5A5, 4'h3);
        tick();
        req_valid_i = 1'b0;
        chk("flc_breq", bus_req_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flc_breq_cleared", bus_req_o, 0);
        chk("flc_busy", busy_o, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
